// File: rtl/loader_pkg.sv
// Shared types and constants for the loader write sequencer and its window decoders.
package loader_pkg;

    localparam int MAX_WINDOWS = 4;
    localparam int WIN_IDX_W   = $clog2(MAX_WINDOWS);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Byte 0 is the most significant byte of the big-endian word.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/loader_window_decode.sv
// Range check and address translation for a single remap window.
module loader_window_decode #(
    parameter logic [31:0] BASE   = 32'h0,
    parameter logic [31:0] MAP    = 32'h0,
    parameter logic [15:0] LENGTH = 16'd0
) (
    input  logic [31:0] address,
    output logic        hit,
    output logic [31:0] mapped
);

    // 33-bit end so a window reaching the top of the address space does not wrap to zero.
    localparam logic [32:0] WINDOW_END = {1'b0, BASE} + {17'b0, LENGTH};

    assign hit    = (LENGTH != 16'd0) && (address >= BASE) && ({1'b0, address} < WINDOW_END);
    assign mapped = address - BASE + MAP;

endmodule

// File: rtl/loader_write_sequencer.sv
// Splits loader word writes into four remapped byte writes, dropping bytes no window claims.
module loader_write_sequencer
    import loader_pkg::*;
#(
    parameter int                      N_WINDOWS    = 2,
    parameter logic [N_WINDOWS*32-1:0] BASE_ADDRESS = '0,
    parameter logic [N_WINDOWS*32-1:0] MAP_ADDRESS  = '0,
    parameter logic [N_WINDOWS*16-1:0] MAP_LENGTH   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_address,
    input  logic [31:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIN_IDX_W-1:0] out_window,
    output logic [31:0]          out_address,
    output logic [7:0]           out_data,
    output logic                 busy,
    output logic [15:0]          dropped_count
);

    state_t                 state;
    logic [1:0]             byte_idx;
    logic [1:0]             next_idx;
    logic [31:0]            word_address;
    logic [31:0]            word_data;
    logic [31:0]            dec_address;
    logic [7:0]             dec_data;
    logic [N_WINDOWS-1:0]   hit;
    logic [31:0]            mapped [N_WINDOWS];
    logic                   any_hit;
    logic [WIN_IDX_W-1:0]   sel_window;
    logic [31:0]            sel_address;

    assign next_idx = byte_idx + 2'd1;
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Decode the byte that will be presented next: byte 0 of the incoming word while idle,
    // otherwise the byte after the one currently on the output.
    always_comb begin
        dec_address = 32'h0;
        dec_data    = 8'h0;
        if (state == IDLE) begin
            dec_address = in_address & 32'hFFFF_FFFC;
            dec_data    = in_data[31:24];
        end else begin
            dec_address = word_address | {30'b0, next_idx};
            dec_data    = word_byte(word_data, next_idx);
        end
    end

    for (genvar g = 0; g < N_WINDOWS; g++) begin : g_window
        loader_window_decode #(
            .BASE   (BASE_ADDRESS[g*32 +: 32]),
            .MAP    (MAP_ADDRESS[g*32 +: 32]),
            .LENGTH (MAP_LENGTH[g*16 +: 16])
        ) u_decode (
            .address (dec_address),
            .hit     (hit[g]),
            .mapped  (mapped[g])
        );
    end

    // Scanning from the top index down lets the lowest hitting window overwrite the others.
    always_comb begin
        any_hit     = 1'b0;
        sel_window  = '0;
        sel_address = 32'h0;
        for (int i = N_WINDOWS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit     = 1'b1;
                sel_window  = WIN_IDX_W'(i);
                sel_address = mapped[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_idx      <= 2'd0;
            word_address  <= 32'h0;
            word_data     <= 32'h0;
            out_valid     <= 1'b0;
            out_window    <= '0;
            out_address   <= 32'h0;
            out_data      <= 8'h0;
            dropped_count <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state        <= SEND;
                        word_address <= dec_address;
                        word_data    <= in_data;
                        byte_idx     <= 2'd0;
                        out_valid    <= any_hit;
                        out_window   <= any_hit ? sel_window : '0;
                        out_address  <= any_hit ? sel_address : 32'h0;
                        out_data     <= any_hit ? dec_data : 8'h0;
                    end
                end
                SEND: begin
                    // An unclaimed byte occupies exactly one cycle with out_valid low.
                    if (!out_valid || out_ready) begin
                        if (!out_valid && dropped_count != 16'hFFFF) begin
                            dropped_count <= dropped_count + 16'd1;
                        end
                        if (byte_idx == 2'd3) begin
                            state       <= IDLE;
                            byte_idx    <= 2'd0;
                            out_valid   <= 1'b0;
                            out_window  <= '0;
                            out_address <= 32'h0;
                            out_data    <= 8'h0;
                        end else begin
                            byte_idx    <= next_idx;
                            out_valid   <= any_hit;
                            out_window  <= any_hit ? sel_window : '0;
                            out_address <= any_hit ? sel_address : 32'h0;
                            out_data    <= any_hit ? dec_data : 8'h0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
